// File: rtl/sim_ctrl.sv
// sim_ctrl: simulation harness controller.
// Stretches the external reset into sys_rst, buffers stimulus bytes in a FIFO,
// serialises them as 8N1 UART frames on rx_out once the DUT is out of reset,
// counts run cycles and latches a sticky done flag on request.
// Optional feature: define SIM_CTRL_TIMEOUT_EN to force done/timeout when
// cycle_cnt reaches TIMEOUT_CYCLES; without it timeout is tied low.
// Parameter ranges assumed: RST_CYCLES >= 1, CLKS_PER_BIT >= 2,
// DEPTH a power of 2 and >= 2.
module sim_ctrl #(
   parameter int RST_CYCLES     = 25,
   parameter int CLKS_PER_BIT   = 4,
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        finish_req,
   output logic        sys_rst,
   output logic        rx_out,
   output logic [31:0] cycle_cnt,
   output logic        done,
   output logic        timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;

   logic          sys_rst_q, sys_rst_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   uart_state_e   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          rx_q, rx_d;

   logic [31:0]   cycle_cnt_q, cycle_cnt_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;

   logic          push;
   logic          pop;
   logic          run_active;
   logic          launch;
   logic          bit_end;

   assign in_ready   = (count_q != (AW+1)'(DEPTH));
   assign push       = in_valid && in_ready;
   assign run_active = !sys_rst_q && !done_q;
   assign launch     = run_active && (count_q != '0);
   assign bit_end    = (baud_q == BW'(CLKS_PER_BIT - 1));

   // Reset stretcher: count rising edges after rst falls, then release sys_rst.
   always_comb begin
      sys_rst_d = sys_rst_q;
      rst_cnt_d = rst_cnt_q;
      if (sys_rst_q) begin
         if (int'(rst_cnt_q) >= RST_CYCLES - 1) begin
            sys_rst_d = 1'b0;
         end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
         end
      end
   end

   // FIFO pointer and occupancy update from the push/pop strobes.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // UART transmitter next state; a launch pops the FIFO and drives the start bit.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      rx_d      = rx_q;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rx_d = 1'b1;
            if (launch) begin
               pop     = 1'b1;
               state_d = ST_START;
               baud_d  = '0;
               shift_d = mem_q[rd_ptr_q];
               rx_d    = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               baud_d    = '0;
               bit_idx_d = '0;
               rx_d      = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
                  rx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  rx_d      = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (launch) begin
                  pop     = 1'b1;
                  state_d = ST_START;
                  shift_d = mem_q[rd_ptr_q];
                  rx_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  rx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rx_d    = 1'b1;
         end
      endcase
   end

   // Run bookkeeping: saturating cycle counter, sticky done and timeout flags.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      done_d      = done_q;
      timeout_d   = timeout_q;
      if (run_active) begin
         if (cycle_cnt_q != '1) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
         end
         if (finish_req) begin
            done_d = 1'b1;
         end
`ifdef SIM_CTRL_TIMEOUT_EN
         if (cycle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            done_d    = 1'b1;
            timeout_d = 1'b1;
         end
`else
         timeout_d = 1'b0;
`endif
      end
   end

   // FIFO storage; contents need no reset because the pointers define emptiness.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // All control state, with rst forcing the idle/empty/in-reset condition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_rst_q   <= 1'b1;
         rst_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= ST_IDLE;
         baud_q      <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_q        <= 1'b1;
         cycle_cnt_q <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         sys_rst_q   <= sys_rst_d;
         rst_cnt_q   <= rst_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_q        <= rx_d;
         cycle_cnt_q <= cycle_cnt_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign sys_rst   = sys_rst_q;
   assign rx_out    = rx_q;
   assign cycle_cnt = cycle_cnt_q;
   assign done      = done_q;
   assign timeout   = timeout_q;

endmodule

// File: doc/sim_ctrl.md
SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 25: cycles sys_rst stays high after rst falls.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clk cycles per UART bit (≥2).
REQ-003 SHALL have parameter DEPTH, default 16: stimulus byte FIFO depth (power of 2, ≥2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2000: run-cycle limit before forced finish.
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  stimulus byte offered.
REQ-008 SHALL have port in_data  input  8  stimulus byte.
REQ-009 SHALL have port in_ready  output  1  FIFO not full.
REQ-010 SHALL have port finish_req  input  1  DUT/bench requests end of run.
REQ-011 SHALL have port sys_rst  output  1  stretched reset driven to DUT btnC.
REQ-012 SHALL have port rx_out  output  1  UART serial line driven to DUT Rx.
REQ-013 SHALL have port cycle_cnt  output  32  run cycles since sys_rst fell.
REQ-014 SHALL have port done  output  1  sticky run-finished flag.
REQ-015 SHALL have port timeout  output  1  sticky flag: finish caused by cycle limit.

Function
REQ-016 SHALL hold sys_rst=1 through rst and exactly RST_CYCLES rising edges after rst falls, then 0 until next rst.
REQ-017 SHALL accept a byte on any edge with in_valid&&in_ready, including during sys_rst; in_ready = !full, combinational from FIFO count.
REQ-018 SHALL, when full, drop nothing: in_ready=0 so push does not occur; a same-cycle pop frees space visible next cycle.
REQ-019 SHALL, push into empty FIFO, make the byte poppable no earlier than the following cycle.
REQ-020 SHALL run UART FSM IDLE->START->DATA->STOP->IDLE; each state bit lasts CLKS_PER_BIT cycles; DATA sends 8 bits LSB first.
REQ-021 SHALL leave IDLE only when sys_rst=0, done=0, FIFO non-empty; pop occurs on that edge, rx_out=0 from that edge.
REQ-022 SHALL drive rx_out registered: 1 in IDLE/STOP, 0 in START, data bit in DATA; frame total 10*CLKS_PER_BIT cycles.
REQ-023 SHALL go STOP->START directly (back-to-back frames, no idle gap) if launch condition of REQ-021 holds at STOP end.
REQ-024 SHALL increment cycle_cnt each cycle with sys_rst=0 and done=0, saturating at 2^32-1.
REQ-025 SHALL set done on the edge after finish_req=1 sampled with sys_rst=0; done stays until rst.
REQ-026 SHALL, once done, launch no new frame; a frame in progress completes, then rx_out stays 1.
REQ-027 SHALL ignore finish_req while sys_rst=1.

Reset
REQ-028 SHALL on rst asynchronously force: sys_rst=1, rx_out=1, FSM IDLE, FIFO empty, cycle_cnt=0, done=0, timeout=0.
REQ-029 SHALL, on rst mid-frame, abort the frame immediately (rx_out=1) and discard FIFO contents.

Configuration
REQ-030 SHALL, with SIM_CTRL_TIMEOUT_EN defined, set timeout=1 and done=1 on the edge where cycle_cnt would reach TIMEOUT_CYCLES; simultaneous finish_req sets done with timeout=1.
REQ-031 SHALL, without SIM_CTRL_TIMEOUT_EN, tie timeout=0 and end runs only via finish_req; TIMEOUT_CYCLES unused.

Verification
REQ-032 SHALL test reset stretch: rst high 25 edges then low, RST_CYCLES=25 -> sys_rst falls on 25th edge after rst falls, cycle_cnt=0 at that edge.
REQ-033 SHALL test single frame: push 0xA5 during sys_rst, CLKS_PER_BIT=4 -> rx_out 1 until reset ends, then 0(4),1,0,1,0,0,1,0,1 (4 each),1(4), in_ready stays 1.
REQ-034 SHALL test full FIFO: DEPTH=16, hold in_valid for 20 cycles with sys_rst=1 -> exactly 16 accepted, in_ready=0 after 16th, bytes 0x00..0x0F sent back-to-back in order.
REQ-035 SHALL test timeout (macro defined, TIMEOUT_CYCLES=2000) -> timeout=1, done=1 with cycle_cnt=2000 and held; undefined -> timeout=0 at 5000 cycles.
REQ-036 SHALL test finish mid-frame: 3 bytes queued, finish_req pulse during byte 1 DATA -> byte 1 completes, bytes 2-3 never sent, done=1, timeout=0, cycle_cnt frozen.
REQ-037 SHALL test rst mid-frame: assert rst during DATA of byte 2 -> rx_out=1 same time step, in_ready=1, no further frames after reset without new pushes.
